// File: rtl/present_decrypt.sv
// PRESENT-80 block decryptor: forward key schedule to K32, then 31 inverse rounds.
// Optional last-round-key cache enabled by defining PRESENT_DECRYPT_KEY_CACHE_EN.
module present_decrypt (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [79:0] key,
    input  logic [63:0] ciphertext,
    input  logic        start_in,
    output logic [63:0] decrypted_text,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, KEYGEN, WHITEN, ROUND} state_t;

    // Nibble n of each constant is the S-box output for input n.
    localparam logic [63:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;

    state_t      state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [63:0] data_q, data_d;
    logic [63:0] result_q, result_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

`ifdef PRESENT_DECRYPT_KEY_CACHE_EN
    logic [79:0] cache_user_q, cache_user_d;
    logic [79:0] cache_k32_q, cache_k32_d;
    logic        cache_vld_q, cache_vld_d;
    logic        hit;

    assign hit = cache_vld_q && (key == cache_user_q);
`endif

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [79:0] key_fwd(input logic [79:0] k,
                                            input logic [4:0]  rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    function automatic logic [79:0] key_inv(input logic [79:0] k,
                                            input logic [4:0]  rc);
        logic [79:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ rc;
        r[79:76]   = inv_sbox(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

    function automatic logic [63:0] inv_player(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 63; i++) begin
            r[i] = s[(i * 16) % 63];
        end
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [63:0] inv_slayer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = inv_sbox(s[4*n +: 4]);
        end
        return r;
    endfunction

    // Next-state, datapath and key-schedule updates for the decryption FSM.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        data_d   = data_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
`ifdef PRESENT_DECRYPT_KEY_CACHE_EN
        cache_user_d = cache_user_q;
        cache_k32_d  = cache_k32_q;
        cache_vld_d  = cache_vld_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    data_d = ciphertext;
                    cnt_d  = 5'd1;
`ifdef PRESENT_DECRYPT_KEY_CACHE_EN
                    if (hit) begin
                        key_d   = cache_k32_q;
                        state_d = WHITEN;
                    end else begin
                        key_d        = key;
                        state_d      = KEYGEN;
                        cache_user_d = key;
                        cache_vld_d  = 1'b0;
                    end
`else
                    key_d   = key;
                    state_d = KEYGEN;
`endif
                end
            end
            KEYGEN: begin
                key_d = key_fwd(key_q, cnt_q);
                if (cnt_q == 5'd31) begin
                    state_d = WHITEN;
`ifdef PRESENT_DECRYPT_KEY_CACHE_EN
                    cache_k32_d = key_d;
                    cache_vld_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            WHITEN: begin
                data_d  = data_q ^ key_q[79:16];
                cnt_d   = 5'd31;
                state_d = ROUND;
            end
            ROUND: begin
                key_d  = key_inv(key_q, cnt_q);
                data_d = inv_slayer(inv_player(data_q)) ^ key_d[79:16];
                if (cnt_q == 5'd1) begin
                    result_d = data_d;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
        endcase
    end

    // State, datapath and result registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            key_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            data_q   <= data_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

`ifdef PRESENT_DECRYPT_KEY_CACHE_EN
    // Last-round-key cache; reset invalidates it so aborted work is never reused.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cache_user_q <= '0;
            cache_k32_q  <= '0;
            cache_vld_q  <= 1'b0;
        end else begin
            cache_user_q <= cache_user_d;
            cache_k32_q  <= cache_k32_d;
            cache_vld_q  <= cache_vld_d;
        end
    end
`endif

    assign decrypted_text = result_q;
    assign done           = done_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: doc/present_decrypt.md
PRESENT_DECRYPT -- requirements
Module: present_decrypt

Interface
REQ-001 The block SHALL have exactly one clock and the ports below; no parameters.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 key  input  80  PRESENT-80 user key, sampled with start_in.
REQ-005 ciphertext  input  64  block to decrypt, sampled with start_in.
REQ-006 start_in  input  1  request strobe, sampled only in IDLE.
REQ-007 decrypted_text  output  64  registered plaintext result, held until the next result or reset.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when decrypted_text updates.

Function
REQ-010 FSM states SHALL be IDLE, KEYGEN, WHITEN, ROUND; busy = (state != IDLE).
REQ-011 IDLE with start_in=1 at an edge: latch ciphertext into state reg, key into key reg, goto KEYGEN, counter=1.
REQ-012 KEYGEN, per edge: key reg <= forward update (rotl 61, S-box on [79:76], [19:15] ^= counter); counter++; after counter=31 update goto WHITEN.
REQ-013 WHITEN, one edge: state ^= key[79:16] (K32); counter=31; goto ROUND.
REQ-014 ROUND, per edge: key reg <= inverse update using counter ([19:15] ^= counter, inverse S-box on [79:76], rotr 61); state <= invS(invP(state)) ^ new key[79:16]; counter--.
REQ-015 The ROUND edge with counter=1 SHALL write decrypted_text, pulse done next cycle, return to IDLE.
REQ-016 Latency: done high in the cycle after the 63rd edge following the sampling edge (1 load + 30 further KEYGEN + 1 WHITEN + 31 ROUND).
REQ-017 invP SHALL be the inverse of PRESENT pLayer (bit i*16 mod 63 -> i, bit 63 fixed); invS SHALL be the inverse PRESENT S-box applied to all 16 nibbles.
REQ-018 start_in while busy SHALL be ignored; no queuing; key/ciphertext changes while busy SHALL have no effect.
REQ-019 start_in held high SHALL start a new operation on the first IDLE edge after done, giving back-to-back operation with one IDLE cycle.
REQ-020 Counter SHALL be 5 bits; XOR into key bits [19:15] exactly as specified, no wrap beyond 1..31.

Reset
REQ-021 reset_n low at an edge SHALL force IDLE, decrypted_text=0, done=0, busy=0, key/state/counter regs=0, overriding any state incl. mid-KEYGEN/ROUND.
REQ-022 start_in sampled together with reset_n low SHALL be discarded.
REQ-023 First start SHALL be accepted on the first edge with reset_n high.

Configuration
REQ-024 Macro PRESENT_DECRYPT_KEY_CACHE_EN SHALL compile in a last-round-key cache: 80-bit cached user key, 80-bit K32 state, valid bit.
REQ-025 With macro: on start, if valid and key equals cached user key, load K32 directly, skip KEYGEN to WHITEN; done after edge 32. On miss, normal path, and cache filled when KEYGEN completes.
REQ-026 With macro: reset SHALL clear the valid bit; an aborted KEYGEN SHALL not fill the cache.
REQ-027 Without macro: no cache logic; every operation takes the REQ-016 latency.

Verification
REQ-028 key=0, ciphertext=5579C1387B228445, start pulse -> decrypted_text=0000000000000000, done one cycle, 63 edges after start.
REQ-029 key=FFFFFFFFFFFFFFFFFFFF, ciphertext=E72C46C0F5945049 -> 0000000000000000; key=FFFF...(80b), ciphertext=3333DCD3213210D2 -> FFFFFFFFFFFFFFFF.
REQ-030 key=0, ciphertext=A112FFC72F68417B, start held high for 200 cycles -> repeated results FFFFFFFFFFFFFFFF, one done per 64 cycles, busy low exactly one cycle between.
REQ-031 Start, reset_n low at edge 20 of ROUND for one cycle -> all outputs 0 next cycle, no done; new start then completes correctly.
REQ-032 Pulses of start_in while busy -> no extra done, result unaffected.
REQ-033 With PRESENT_DECRYPT_KEY_CACHE_EN: two decrypts with key=0 -> second done after 32 edges; then key=FFFF... -> 63 edges; after reset, same key -> 63 edges.
